dct_stream: RTL

- Parametrised N-point 1-D integer DCT-II engine; successor to the fixed 8-bit-in/10-bit-out serial DCT.
- Accepts one frame of N unsigned samples serially and computes N signed coefficients using the HEVC integer matrix.
- Streams coefficients out with a valid/ready handshake and a last-of-frame flag.
- Sits between the pixel line buffer and the quantiser; both neighbours may stall.

---
 rtl/dct_pkg.sv | 37 +++
 rtl/dct_mac_row.sv | 30 +++
 rtl/dct_stream.sv | 87 ++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared FSM states, HEVC integer DCT matrices and arithmetic helpers
package dct_pkg;

    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

    localparam int C4 [4][4] = '{
        '{64,  64,  64,  64},
        '{83,  36, -36, -83},
        '{64, -64, -64,  64},
        '{36, -83,  83, -36}
    };

    localparam int C8 [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };

    function automatic logic signed [7:0] coef(input int n, input int k, input int i);
        return 8'(n == 8 ? C8[k][i] : C4[k][i]);
    endfunction

    // Clamp to the signed range of a w-bit result; caller truncates to w bits.
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/dct_mac_row.sv
// dct_mac_row: one DCT output coefficient as a rounded, shifted, saturated dot product
module dct_mac_row
    import dct_pkg::*;
#(
    parameter int N     = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 10,
    parameter int SHIFT = 7
) (
    input  logic [IN_W-1:0]          x [N],
    input  logic [$clog2(N)-1:0]     k,
    output logic signed [OUT_W-1:0]  y
);

    localparam int ACC_W = IN_W + 8 + $clog2(N) + 1;
    localparam int RND   = 1 << (SHIFT - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;

    // Samples are zero-extended before the signed multiply; shift is a floor shift.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++)
            acc = acc + ACC_W'($signed({1'b0, x[i]})) * ACC_W'(coef(N, int'(k), i));
        shifted = (acc + ACC_W'(RND)) >>> SHIFT;
        y = OUT_W'(sat(32'(shifted), OUT_W));
    end

endmodule

// File: rtl/dct_stream.sv
// dct_stream: serial-in / serial-out N-point integer DCT-II with valid/ready handshakes
module dct_stream
    import dct_pkg::*;
#(
    parameter int N     = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 10,
    parameter int SHIFT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    if (N != 4 && N != 8) begin : g_bad_n
        $error("dct_stream: N must be 4 or 8");
    end

    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] LAST = KW'(N - 1);

    state_t                  state;
    logic [KW-1:0]           cnt;
    logic [IN_W-1:0]         xbuf [N];
    logic signed [OUT_W-1:0] ybuf [N];
    logic signed [OUT_W-1:0] y;

    dct_mac_row #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_row (
        .x (xbuf),
        .k (cnt),
        .y (y)
    );

    // One counter serves all three phases; it wraps to 0 at each phase end since N is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        xbuf[cnt] <= in_data;
                        cnt       <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state    <= CALC;
                            in_ready <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    ybuf[cnt] <= y;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) state <= DRAIN;
                end
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= ybuf[cnt];
                            out_last  <= (cnt == LAST);
                            cnt       <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
